// File: rtl/pc16_fetch.sv
// 16-bit program counter / fetch stage with Hack-style jump evaluation.
// Define PC16_RAS_EN to build the circular return-address stack (call/ret).
module inc16 (
  input  logic [15:0] in,
  output logic [15:0] out
);
  assign out = in + 16'd1;
endmodule

module pc16_fetch #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int          RAS_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_ready,
  input  logic        load,
  input  logic        inc,
  input  logic [15:0] in,
  input  logic [2:0]  jump,
  input  logic        zr,
  input  logic        ng,
  input  logic        call,
  input  logic        ret,
  output logic [15:0] out,
  output logic        fetch_valid,
  output logic        wrapped,
  output logic        ras_err
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state, state_nxt;
  logic        adv, taken;
  logic [15:0] pc_inc, nxt, pop_val;
  logic        wrap_nxt, push, pop;
  logic        ras_call, ras_ret;

  inc16 u_inc (.in(out), .out(pc_inc));

  assign adv   = fetch_valid & fetch_ready;
  assign taken = (jump[2] & ng) | (jump[1] & zr) | (jump[0] & ~ng & ~zr);

  always_comb begin
    state_nxt   = state;
    fetch_valid = 1'b0;
    unique case (state)
      BOOT: state_nxt = RUN;
      RUN:  fetch_valid = 1'b1;
    endcase
  end

  always_comb begin
    nxt      = out;
    wrap_nxt = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    if (adv) begin
      if (ras_ret) begin
        pop = 1'b1;
        nxt = pop_val;
      end else if (ras_call) begin
        push = 1'b1;
        nxt  = in;
      end else if (load | taken) begin
        nxt = in;
      end else if (inc) begin
        nxt      = pc_inc;
        wrap_nxt = (out == 16'hFFFF);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= BOOT;
      out     <= RESET_VECTOR;
      wrapped <= 1'b0;
    end else begin
      state   <= state_nxt;
      out     <= nxt;
      wrapped <= wrap_nxt;
    end
  end

`ifdef PC16_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [15:0]   stk [RAS_DEPTH];
  logic [PW-1:0] sp, sp_inc, sp_dec;
  logic [CW-1:0] cnt;
  logic          full, empty;

  assign ras_call = call;
  assign ras_ret  = ret;
  assign full     = (cnt == CW'(RAS_DEPTH));
  assign empty    = (cnt == '0);
  assign sp_inc   = (sp == PW'(RAS_DEPTH - 1)) ? '0 : sp + PW'(1);
  assign sp_dec   = (sp == '0) ? PW'(RAS_DEPTH - 1) : sp - PW'(1);
  assign pop_val  = empty ? 16'h0000 : stk[sp_dec];

  // sp is the next free slot; when full it also holds the oldest entry
  always_ff @(posedge clk) begin
    if (reset) begin
      sp      <= '0;
      cnt     <= '0;
      ras_err <= 1'b0;
    end else if (pop) begin
      if (empty) begin
        ras_err <= 1'b1;
      end else begin
        sp  <= sp_dec;
        cnt <= cnt - CW'(1);
      end
    end else if (push) begin
      sp <= sp_inc;
      if (full) ras_err <= 1'b1;
      else      cnt     <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push && !pop) stk[sp] <= pc_inc;
  end
`else
  logic unused_ras;

  assign ras_call   = 1'b0;
  assign ras_ret    = 1'b0;
  assign pop_val    = 16'h0000;
  assign ras_err    = 1'b0;
  assign unused_ras = call ^ ret ^ push ^ pop ^ (RAS_DEPTH == 0);
`endif

endmodule

// File: doc/pc16_fetch.md
Name: pc16_fetch

Overview:
- 16-bit program counter stage that sits directly downstream of the 16-bit incrementer and consumes its output.
- Holds the current instruction address and drives it to instruction memory through a valid/ready fetch handshake.
- Selects the next address from: the incrementer result, a load/jump target, or the current value (hold).
- Evaluates Hack-style jump bits against ALU flags.

Parameters:
- RESET_VECTOR, 16'h0000, value loaded into out on reset.
- RAS_DEPTH, 4, return-address-stack entries (used only with PC16_RAS_EN).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- fetch_ready  input  1  instruction memory accepts current address.
- load  input  1  unconditional load of in.
- inc  input  1  request increment.
- in  input  16  load/jump/call target.
- jump  input  3  {j1,j2,j3}: jump if ng / zr / positive.
- zr  input  1  ALU zero flag.
- ng  input  1  ALU negative flag.
- call  input  1  push return address, load in (PC16_RAS_EN only).
- ret  input  1  pop return address (PC16_RAS_EN only).
- out  output  16  current PC / fetch address.
- fetch_valid  output  1  out is a valid fetch request.
- wrapped  output  1  one-cycle pulse: increment from 16'hFFFF to 16'h0000.
- ras_err  output  1  sticky: RAS overflow or underflow.

Behaviour:
- Reset (sync, reset=1 at edge): out=RESET_VECTOR, state=BOOT, fetch_valid=0, wrapped=0, ras_err=0, RAS pointer=0, RAS count=0. Reset overrides every other input in the same cycle, including mid-handshake.
- FSM states:
  - BOOT: fetch_valid=0. Next cycle goes to RUN unconditionally, giving exactly one bubble after reset deasserts.
  - RUN: fetch_valid=1. Stays in RUN until reset.
- adv = fetch_valid & fetch_ready. out changes only on cycles with adv=1; otherwise out holds and all control inputs are ignored.
- taken = (j1&ng) | (j2&zr) | (j3&~ng&~zr).
- Next-address priority on adv:
  - ret
  - call
  - load or taken → in
  - inc → Inc16(out), computed by the existing incrementer instance, not a new adder
  - else hold.
- Wrap-around: inc at 16'hFFFF gives 16'h0000 and wrapped=1 for exactly the following cycle. No other path sets wrapped.
- Latency: the new out is visible one cycle after the adv edge. fetch_valid stays high while out changes (back-to-back fetches, one per cycle when fetch_ready=1).
- zr and ng both 1 (illegal from the ALU): treated literally per the taken equation.
- Without PC16_RAS_EN, call and ret are ignored and ras_err is tied to 0.

Optional Feature:
- Macro: PC16_RAS_EN.
- When defined, a RAS_DEPTH-entry circular return-address stack is built:
  - call on adv pushes Inc16(out) and loads in.
  - ret on adv pops the top entry into out.
  - call and ret together: ret wins, no push.
  - Push when full: overwrites the oldest entry, count stays RAS_DEPTH, ras_err set.
  - Pop when empty: out=16'h0000, ras_err set.
  - ras_err clears only on reset.
- When undefined: no stack storage is built, call/ret have no effect, ras_err=0.

Test Plan:
- Reset then run: reset=1 for 2 cycles, release, fetch_ready=1, inc=1 → fetch_valid 0 for one cycle after release, then out 0000, 0001, 0002, 0003 on consecutive cycles.
- Stall: out=0005, fetch_ready=0 for 3 cycles with inc=1, load=1, in=1234 → out stays 0005. fetch_ready=1 → out=1234 next cycle (load beats inc).
- Jump: out=0010, jump=3'b010, zr=1, in=0040, inc=1 → out=0040. Same with zr=0, ng=0, jump=3'b010 → out=0011. jump=3'b001, zr=0, ng=0 → taken.
- Wrap: load in=FFFE, then inc twice → out FFFF then 0000, wrapped=1 for one cycle only.
- Reset mid-operation: in RUN at out=0ABC with load=1, in=2222, reset=1 → out=RESET_VECTOR, fetch_valid=0 next cycle, load ignored.
- PC16_RAS_EN: from out=0100, call in=0200 → out=0200. ret → out=0101. 5 calls with depth 4 → ras_err=1. 5 rets after that → the 5th returns 0000.
